// File: rtl/pool2d_stream.sv
// pool2d_stream: windowed max/avg pooling from the CONV BRAM into the POOL BRAM.
// Define POOL2D_RELU_EN to clamp negative pooled results to zero.
module pool2d_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IN_H       = 28,
    parameter int IN_W       = 28,
    parameter int POOL       = 2,
    parameter int STRIDE     = 2,
    parameter int MODE       = 0,
    parameter int RD_LAT     = 1,
    localparam int OUT_H     = (IN_H - POOL) / STRIDE + 1,
    localparam int OUT_W     = (IN_W - POOL) / STRIDE + 1,
    localparam int CONV_N    = CHANNELS * IN_H * IN_W,
    localparam int POOL_N    = CHANNELS * OUT_H * OUT_W,
    localparam int CONV_AW   = (CONV_N > 1) ? $clog2(CONV_N) : 1,
    localparam int POOL_AW   = (POOL_N > 1) ? $clog2(POOL_N) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic [CONV_AW-1:0]           conv_addr,
    output logic                         conv_en,
    input  logic signed [DATA_WIDTH-1:0] conv_q,
    output logic [POOL_AW-1:0]           pool_addr,
    output logic                         pool_en,
    output logic                         pool_we,
    output logic signed [DATA_WIDTH-1:0] pool_d,
    output logic                         busy,
    output logic                         done
);

    localparam int KK     = POOL * POOL;
    localparam int LOG_KK = $clog2(KK);
    localparam int ACC_W  = DATA_WIDTH + LOG_KK;
    localparam int K_W    = $clog2(POOL + 1);
    localparam int CH_W   = $clog2(CHANNELS + 1);
    localparam int R_W    = $clog2(OUT_H + 1);
    localparam int C_W    = $clog2(OUT_W + 1);

    generate
        if ((MODE == 1 && (KK & (KK - 1)) != 0) || POOL < 1 || POOL > 8 ||
            STRIDE < 1 || STRIDE > POOL || RD_LAT < 1 || RD_LAT > 2) begin : g_bad_cfg
            $error("pool2d_stream: unsupported parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_WRITE,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [CH_W-1:0]         ch_q, ch_d;
    logic [R_W-1:0]          r_q, r_d;
    logic [C_W-1:0]          c_q, c_d;
    logic [K_W-1:0]          i_q, i_d;
    logic [K_W-1:0]          j_q, j_d;
    logic                    lat_q, lat_d;
    logic [RD_LAT-1:0]       vld_q, vld_d;
    logic [RD_LAT-1:0]       fst_q, fst_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] smp;
    logic signed [DATA_WIDTH-1:0] res;
    logic                    issue;

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        r_d     = r_q;
        c_d     = c_q;
        i_d     = i_q;
        j_d     = j_q;
        lat_d   = lat_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (j_q == K_W'(POOL - 1)) begin
                    j_d = '0;
                    if (i_q == K_W'(POOL - 1)) begin
                        i_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        i_d = i_q + K_W'(1);
                    end
                end else begin
                    j_d = j_q + K_W'(1);
                end
            end
            S_DRAIN: begin
                if (lat_q == 1'(RD_LAT - 1)) begin
                    lat_d   = 1'b0;
                    state_d = S_WRITE;
                end else begin
                    lat_d = 1'b1;
                end
            end
            S_WRITE: begin
                state_d = S_ISSUE;
                if (c_q == C_W'(OUT_W - 1)) begin
                    c_d = '0;
                    if (r_q == R_W'(OUT_H - 1)) begin
                        r_d = '0;
                        if (ch_q == CH_W'(CHANNELS - 1)) begin
                            ch_d    = '0;
                            state_d = S_FINISH;
                        end else begin
                            ch_d = ch_q + CH_W'(1);
                        end
                    end else begin
                        r_d = r_q + R_W'(1);
                    end
                end else begin
                    c_d = c_q + C_W'(1);
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Tags travel with each read so the fold knows which sample opens a window.
    always_comb begin
        issue    = (state_q == S_ISSUE);
        vld_d    = vld_q << 1;
        vld_d[0] = issue;
        fst_d    = fst_q << 1;
        fst_d[0] = issue && (i_q == '0) && (j_q == '0);
        smp      = ACC_W'(conv_q);
        acc_d    = acc_q;
        if (vld_q[RD_LAT-1]) begin
            if (fst_q[RD_LAT-1]) begin
                acc_d = smp;
            end else if (MODE == 1) begin
                acc_d = acc_q + smp;
            end else if (smp > acc_q) begin
                acc_d = smp;
            end
        end
    end

    always_comb begin
        if (MODE == 1) begin
            res = DATA_WIDTH'(acc_q >>> LOG_KK);
        end else begin
            res = DATA_WIDTH'(acc_q);
        end
`ifdef POOL2D_RELU_EN
        pool_d = res[DATA_WIDTH-1] ? '0 : res;
`else
        pool_d = res;
`endif
        conv_en   = (state_q == S_ISSUE);
        pool_en   = (state_q == S_WRITE);
        pool_we   = (state_q == S_WRITE);
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FINISH);
        conv_addr = CONV_AW'((32'(ch_q) * IN_H + 32'(r_q) * STRIDE + 32'(i_q)) * IN_W
                             + 32'(c_q) * STRIDE + 32'(j_q));
        pool_addr = POOL_AW'((32'(ch_q) * OUT_H + 32'(r_q)) * OUT_W + 32'(c_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            r_q     <= '0;
            c_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            lat_q   <= 1'b0;
            vld_q   <= '0;
            fst_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            r_q     <= r_d;
            c_q     <= c_d;
            i_q     <= i_d;
            j_q     <= j_d;
            lat_q   <= lat_d;
            vld_q   <= vld_d;
            fst_q   <= fst_d;
            acc_q   <= acc_d;
        end
    end

endmodule
